axi_rd_req_arbiter: RTL and testbench

//  Two-port arbiter sharing one AXI read master (kick/busy/addr/num interface) between requesters.

---
 rtl/axi_rd_req_arbiter.sv | 111 +++++++++++
 tb/tb_axi_rd_req_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_req_arbiter.sv
// Two-port arbiter sharing one AXI read master: port 0 has fixed priority,
// port 1 is guaranteed a grant after MAX_CONSEC contested port-0 grants.
module axi_rd_req_arbiter #(
    parameter int unsigned MAX_CONSEC = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_kick,
    input  logic [31:0]      r0_addr,
    input  logic [31:0]      r0_num,
    output logic             r0_busy,
    input  logic             r1_kick,
    input  logic [31:0]      r1_addr,
    input  logic [31:0]      r1_num,
    output logic             r1_busy,
    output logic             m_kick,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_num,
    input  logic             m_busy,
    output logic             grant_id,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    localparam int unsigned CONSEC_W = 4;
    localparam int unsigned ADDR_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CONSEC_W-1:0] r_consec;
    logic                r_grant_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_num;
    logic [CNT_W-1:0]    r_grant_cnt0;
    logic [CNT_W-1:0]    r_grant_cnt1;

    logic w_any_kick;
    logic w_pick1;
    logic w_active;

    assign w_any_kick = r0_kick | r1_kick;
    // Port 1 wins when alone, or when port 0 has used up its consecutive budget.
    assign w_pick1    = r1_kick & (~r0_kick | (r_consec == CONSEC_W'(MAX_CONSEC)));
    assign w_active   = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_consec     <= '0;
            r_grant_id   <= 1'b0;
            r_addr       <= '0;
            r_num        <= '0;
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!m_busy && w_any_kick) begin
                        r_state    <= S_ISSUE;
                        r_grant_id <= w_pick1;
                        if (w_pick1) begin
                            r_addr       <= r1_addr;
                            r_num        <= r1_num;
                            r_grant_cnt1 <= r_grant_cnt1 + CNT_W'(1);
                            r_consec     <= '0;
                        end else begin
                            r_addr       <= r0_addr;
                            r_num        <= r0_num;
                            r_grant_cnt0 <= r_grant_cnt0 + CNT_W'(1);
                            if (!r1_kick) begin
                                r_consec <= '0;
                            end else if (r_consec < CONSEC_W'(MAX_CONSEC)) begin
                                r_consec <= r_consec + CONSEC_W'(1);
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (m_busy) begin
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!m_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Only the port that owns the master sees its busy; the loser is never falsely acked.
    assign r0_busy    = w_active & ~r_grant_id & m_busy;
    assign r1_busy    = w_active &  r_grant_id & m_busy;
    assign m_kick     = (r_state == S_ISSUE);
    assign m_addr     = r_addr;
    assign m_num      = r_num;
    assign grant_id   = r_grant_id;
    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;

endmodule

// File: tb/tb_axi_rd_req_arbiter.sv
// Self-checking bench for axi_rd_req_arbiter: scoreboard of expected grants
// plus per-scenario checks of busy views, latency, reset and counter wrap.
module tb_axi_rd_req_arbiter;

    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic [31:0] num;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        r0_kick, r1_kick;
    logic [31:0] r0_addr, r0_num, r1_addr, r1_num;
    logic        r0_busy, r1_busy;
    logic        m_kick;
    logic [31:0] m_addr, m_num;
    logic        m_busy;
    logic        grant_id;
    logic [31:0] grant_cnt0, grant_cnt1;

    logic        ext_busy;
    logic        mst_busy;
    logic        master_en;
    int          master_delay;
    int          master_hold;

    exp_t        sb_q[$];
    int          n_cmp;
    int          n_err;

    assign m_busy = ext_busy | mst_busy;

    axi_rd_req_arbiter #(.MAX_CONSEC(4), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .r0_kick    (r0_kick),
        .r0_addr    (r0_addr),
        .r0_num     (r0_num),
        .r0_busy    (r0_busy),
        .r1_kick    (r1_kick),
        .r1_addr    (r1_addr),
        .r1_num     (r1_num),
        .r1_busy    (r1_busy),
        .m_kick     (m_kick),
        .m_addr     (m_addr),
        .m_num      (m_num),
        .m_busy     (m_busy),
        .grant_id   (grant_id),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream master model: accept m_kick after master_delay cycles, stay busy master_hold cycles.
    initial begin
        mst_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (master_en && m_kick) begin
                repeat (master_delay) @(posedge clk);
                #1 mst_busy = 1'b1;
                repeat (master_hold) @(posedge clk);
                #1 mst_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst      = 1'b1;
        r0_kick  = 1'b0;
        r1_kick  = 1'b0;
        ext_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_kick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_kick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Requester side of a granted burst: drop kick one cycle after busy, then wait for idle.
    task automatic finish_burst(input bit port, output bit ok);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((port ? r1_busy : r0_busy) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        @(negedge clk);
        if (port) r1_kick = 1'b0;
        else      r0_kick = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_busy === 1'b0) begin
                ok = seen;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({m_kick, m_addr, m_num, grant_id, grant_cnt0, grant_cnt1, r0_busy, r1_busy} !== '0) begin
            n_err++;
            $display("FAIL reset_values: kick=%b addr=%h num=%h id=%b c0=%0d c1=%0d required all zero",
                     m_kick, m_addr, m_num, grant_id, grant_cnt0, grant_cnt1);
        end
    endtask

    task automatic test_single_port0();
        exp_t e;
        bool_loop: begin end
        do_reset();
        master_en = 1'b1; master_delay = 3; master_hold = 10;
        r0_addr = 32'h100; r0_num = 32'd64;
        r1_addr = 32'hDEAD0; r1_num = 32'd5;
        r0_kick = 1'b1;
        sb_q.push_back('{1'b0, 32'h100, 32'd64});
        @(negedge clk);
        n_cmp++;
        if (m_kick !== 1'b1) begin
            n_err++;
            $display("FAIL single_latency: m_kick=%b required 1", m_kick);
        end
        e = sb_q.pop_front();
        n_cmp++;
        if ({grant_id, m_addr, m_num} !== {e.id, e.addr, e.num}) begin
            n_err++;
            $display("FAIL single_grant: id=%b addr=%h num=%0d required id=%b addr=%h num=%0d",
                     grant_id, m_addr, m_num, e.id, e.addr, e.num);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r0_busy === 1'b1 && r0_kick) begin
                @(negedge clk);
                r0_kick = 1'b0;
            end
            n_cmp++;
            if (r0_busy !== m_busy || r1_busy !== 1'b0) begin
                n_err++;
                $display("FAIL single_busy_view: r0_busy=%b r1_busy=%b required %b/0",
                         r0_busy, r1_busy, m_busy);
            end
        end
        n_cmp++;
        if (grant_cnt0 !== 32'd1 || grant_cnt1 !== 32'd0 || m_addr !== 32'h100) begin
            n_err++;
            $display("FAIL single_counts: c0=%0d c1=%0d addr=%h required 1 0 100",
                     grant_cnt0, grant_cnt1, m_addr);
        end
    endtask

    task automatic test_fairness();
        exp_t e;
        bit   ok;
        int   consec;
        logic pick;
        do_reset();
        master_en = 1'b1; master_delay = 1; master_hold = 3;
        consec = 0;
        for (int b = 0; b < 10; b++) begin
            r0_addr = 32'h1000 + 32'(b) * 32'h40; r0_num = 32'(b + 1);
            r1_addr = 32'h8000 + 32'(b);          r1_num = 32'(100 + b);
            r0_kick = 1'b1;
            r1_kick = 1'b1;
            pick = (consec == 4);
            consec = pick ? 0 : ((consec < 4) ? consec + 1 : consec);
            sb_q.push_back(pick ? '{1'b1, r1_addr, r1_num} : '{1'b0, r0_addr, r0_num});
            wait_kick(ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL fair_timeout: burst %0d m_kick=%b required 1", b, m_kick);
            end
            e = sb_q.pop_front();
            n_cmp++;
            if ({grant_id, m_addr, m_num} !== {e.id, e.addr, e.num}) begin
                n_err++;
                $display("FAIL fair_grant: burst %0d id=%b addr=%h num=%0d required id=%b addr=%h num=%0d",
                         b, grant_id, m_addr, m_num, e.id, e.addr, e.num);
            end
            finish_burst(e.id, ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL fair_burst_end: burst %0d busy handshake incomplete, required complete", b);
            end
        end
        r0_kick = 1'b0;
        r1_kick = 1'b0;
        n_cmp++;
        if (grant_cnt0 !== 32'd8 || grant_cnt1 !== 32'd2) begin
            n_err++;
            $display("FAIL fair_counts: c0=%0d c1=%0d required 8 2", grant_cnt0, grant_cnt1);
        end
    endtask

    task automatic test_pending_port1();
        exp_t e;
        bit   ok;
        bit   bad;
        do_reset();
        master_en = 1'b1; master_delay = 0; master_hold = 8;
        r0_addr = 32'h2000; r0_num = 32'd16;
        r0_kick = 1'b1;
        sb_q.push_back('{1'b0, 32'h2000, 32'd16});
        wait_kick(ok);
        e = sb_q.pop_front();
        n_cmp++;
        if (!ok || grant_id !== e.id || m_addr !== e.addr) begin
            n_err++;
            $display("FAIL pend_first: ok=%b id=%b addr=%h required 1 %b %h", ok, grant_id, m_addr, e.id, e.addr);
        end
        for (int i = 0; i < 10 && m_busy !== 1'b1; i++) @(negedge clk);
        r0_kick = 1'b0;
        r1_addr = 32'hABC0; r1_num = 32'd7;
        r1_kick = 1'b1;
        sb_q.push_back('{1'b1, 32'hABC0, 32'd7});
        bad = 1'b0;
        for (int i = 0; i < 20 && m_busy === 1'b1; i++) begin
            @(negedge clk);
            if (r1_busy !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL pend_r1_busy: r1_busy rose while port 0 owned master, required 0");
        end
        wait_kick(ok);
        e = sb_q.pop_front();
        n_cmp++;
        if (!ok || {grant_id, m_addr, m_num} !== {e.id, e.addr, e.num}) begin
            n_err++;
            $display("FAIL pend_grant: ok=%b id=%b addr=%h num=%0d required 1 %b %h %0d",
                     ok, grant_id, m_addr, m_num, e.id, e.addr, e.num);
        end
        r1_addr = 32'h5555; r1_num = 32'd99;
        finish_burst(1'b1, ok);
        n_cmp++;
        if (!ok || m_addr !== 32'hABC0 || m_num !== 32'd7) begin
            n_err++;
            $display("FAIL pend_hold_addr: ok=%b addr=%h num=%0d required 1 abc0 7", ok, m_addr, m_num);
        end
    endtask

    task automatic test_busy_block();
        exp_t e;
        bit   bad;
        bit   ok;
        do_reset();
        master_en = 1'b0;
        ext_busy  = 1'b1;
        r0_addr = 32'h200; r0_num = 32'd16;
        r0_kick = 1'b1;
        sb_q.push_back('{1'b0, 32'h200, 32'd16});
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_kick !== 1'b0 || r0_busy !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL block_no_kick: m_kick/r0_busy rose under external busy, required 0");
        end
        ext_busy = 1'b0;
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++;
        if (m_kick !== 1'b1 || {grant_id, m_addr, m_num} !== {e.id, e.addr, e.num}) begin
            n_err++;
            $display("FAIL block_release: kick=%b id=%b addr=%h num=%0d required 1 %b %h %0d",
                     m_kick, grant_id, m_addr, m_num, e.id, e.addr, e.num);
        end
        ext_busy = 1'b1;
        finish_burst(1'b0, ok);
        ext_busy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        exp_t e;
        bit   ok;
        do_reset();
        master_en = 1'b0;
        r0_addr = 32'h300; r0_num = 32'd12;
        r0_kick = 1'b1;
        @(negedge clk);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (m_kick !== 1'b1 || m_addr !== 32'h300) begin
            n_err++;
            $display("FAIL rst_hold_kick: kick=%b addr=%h required 1 300", m_kick, m_addr);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({m_kick, m_addr, m_num, grant_id, grant_cnt0, grant_cnt1, r0_busy} !== '0) begin
            n_err++;
            $display("FAIL rst_async: kick=%b addr=%h num=%h c0=%0d c1=%0d required all zero",
                     m_kick, m_addr, m_num, grant_cnt0, grant_cnt1);
        end
        r0_kick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        master_en = 1'b1; master_delay = 1; master_hold = 2;
        r1_addr = 32'h440; r1_num = 32'd3;
        r1_kick = 1'b1;
        sb_q.push_back('{1'b1, 32'h440, 32'd3});
        wait_kick(ok);
        e = sb_q.pop_front();
        n_cmp++;
        if (!ok || {grant_id, m_addr, m_num} !== {e.id, e.addr, e.num} || grant_cnt1 !== 32'd1 || grant_cnt0 !== 32'd0) begin
            n_err++;
            $display("FAIL rst_regrant: ok=%b id=%b addr=%h c0=%0d c1=%0d required 1 %b %h 0 1",
                     ok, grant_id, m_addr, grant_cnt0, grant_cnt1, e.id, e.addr);
        end
        finish_burst(1'b1, ok);
    endtask

    task automatic test_cnt_wrap();
        exp_t e;
        bit   ok;
        do_reset();
        master_en = 1'b1; master_delay = 1; master_hold = 2;
        force dut.r_grant_cnt1 = 32'hFFFF_FFFF;
        #1 release dut.r_grant_cnt1;
        @(negedge clk);
        n_cmp++;
        if (grant_cnt1 !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL wrap_preload: c1=%h required ffffffff", grant_cnt1);
        end
        r1_addr = 32'h7700; r1_num = 32'd1;
        r1_kick = 1'b1;
        sb_q.push_back('{1'b1, 32'h7700, 32'd1});
        wait_kick(ok);
        e = sb_q.pop_front();
        n_cmp++;
        if (!ok || {grant_id, m_addr} !== {e.id, e.addr} || grant_cnt1 !== 32'd0 || grant_cnt0 !== 32'd0) begin
            n_err++;
            $display("FAIL wrap_count: ok=%b id=%b c0=%0d c1=%h required 1 %b 0 0", ok, grant_id, grant_cnt0, grant_cnt1, e.id);
        end
        finish_burst(1'b1, ok);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        master_en = 1'b0; master_delay = 1; master_hold = 2;
        ext_busy = 1'b0;
        rst = 1'b1;
        r0_kick = 1'b0; r1_kick = 1'b0;
        r0_addr = '0; r0_num = '0; r1_addr = '0; r1_num = '0;
        test_reset();
        test_single_port0();
        test_fairness();
        test_pending_port1();
        test_busy_block();
        test_async_reset();
        test_cnt_wrap();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
